// File: rtl/pulse_defs.sv
// Shared definitions for the pulse sequencer: state encoding and default field widths.
package pulse_defs;

    localparam int N_W_DEF   = 16;
    localparam int GAP_W_DEF = 24;
    localparam int TO_W_DEF  = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector with a programmable history value after reset, so that a level
// already high when reset releases is not mistaken for a new edge.
module edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse sequencer: raises PL_launch, waits for launch_DL, holds a programmed low gap and
// repeats for the latched pulse count; adds abort, per-pulse watchdog and status flags.
module pulse_seq_ctrl
    import pulse_defs::*;
#(
    parameter int N_W   = N_W_DEF,
    parameter int GAP_W = GAP_W_DEF,
    parameter int TO_W  = TO_W_DEF
) (
    input  logic             clk_Seq,
    input  logic             rst,
    input  logic             seq_start,
    input  logic             seq_abort,
    input  logic [N_W-1:0]   n_pulses,
    input  logic [GAP_W-1:0] gap,
    input  logic [TO_W-1:0]  timeout,
    input  logic             launch_DL,
    output logic             PL_launch,
    output logic             busy,
    output logic             seq_done,
    output logic             fault,
    output logic [N_W-1:0]   pulse_idx
);

    seq_state_e       state_q;
    logic             pl_q;
    logic             busy_q;
    logic             done_q;
    logic             fault_q;
    logic [N_W-1:0]   idx_q;
    logic [N_W-1:0]   n_cfg_q;
    logic [GAP_W-1:0] gap_cfg_q;
    logic [TO_W-1:0]  to_cfg_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [TO_W-1:0]  wd_q;

    logic             start_rise;
    logic [N_W-1:0]   idx_d;
    logic             wd_hit_d;

    // History resets high so a start held through reset does not launch a sequence.
    edge_det #(.RST_VAL(1'b1)) u_start_edge (
        .clk    (clk_Seq),
        .rst    (rst),
        .d_i    (seq_start),
        .rise_o (start_rise)
    );

    assign idx_d    = idx_q + 1'b1;
    assign wd_hit_d = (to_cfg_q != '0) && (wd_q == to_cfg_q);

    // NOTE: every register here is assigned with <= so all updates use pre-edge values.
    always_ff @(posedge clk_Seq) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pl_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            idx_q     <= '0;
            n_cfg_q   <= '0;
            gap_cfg_q <= '0;
            to_cfg_q  <= '0;
            gap_cnt_q <= '0;
            wd_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (seq_abort) begin
                state_q <= S_IDLE;
                pl_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_rise) begin
                            n_cfg_q   <= n_pulses;
                            gap_cfg_q <= (gap == '0) ? GAP_W'(1) : gap;
                            to_cfg_q  <= timeout;
                            idx_q     <= '0;
                            fault_q   <= 1'b0;
                            if (n_pulses == '0) begin
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_FIRE;
                                pl_q    <= 1'b1;
                                busy_q  <= 1'b1;
                                wd_q    <= TO_W'(1);
                            end
                        end
                    end
                    S_FIRE: begin
                        if (wd_hit_d) begin
                            state_q <= S_IDLE;
                            pl_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                        end else if (launch_DL) begin
                            pl_q  <= 1'b0;
                            idx_q <= idx_d;
                            if (idx_d == n_cfg_q) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q   <= S_GAP;
                                gap_cnt_q <= gap_cfg_q;
                            end
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                    S_GAP: begin
                        // Gap counter holds the remaining low cycles including this one.
                        if (gap_cnt_q == GAP_W'(1)) begin
                            state_q <= S_FIRE;
                            pl_q    <= 1'b1;
                            wd_q    <= TO_W'(1);
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 1'b1;
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign PL_launch = pl_q;
    assign busy      = busy_q;
    assign seq_done  = done_q;
    assign fault     = fault_q;
    assign pulse_idx = idx_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: a cycle table for reset/edge corners, then directed and random
// sequences checked against an interval-based model of the expected output trace.
module tb_pulse_seq_ctrl;
    import pulse_defs::*;

    localparam int N_W   = N_W_DEF;
    localparam int GAP_W = GAP_W_DEF;
    localparam int TO_W  = TO_W_DEF;
    localparam int L_MAX = 200;

    logic             clk_Seq = 1'b0;
    logic             rst;
    logic             seq_start;
    logic             seq_abort;
    logic [N_W-1:0]   n_pulses;
    logic [GAP_W-1:0] gap;
    logic [TO_W-1:0]  timeout;
    logic             launch_DL;
    logic             PL_launch;
    logic             busy;
    logic             seq_done;
    logic             fault;
    logic [N_W-1:0]   pulse_idx;

    int checks = 0;
    int errors = 0;

    int             d_tab [8];
    logic [N_W-1:0] idx_prev;
    logic           fault_prev;

    typedef struct {
        logic           rst, start, abort, dl;
        int             n, g, to;
        logic           pl, busy, done, fault;
        logic [N_W-1:0] idx;
    } vec_t;

    vec_t tbl [22];

    pulse_seq_ctrl #(.N_W(N_W), .GAP_W(GAP_W), .TO_W(TO_W)) dut (
        .clk_Seq   (clk_Seq),
        .rst       (rst),
        .seq_start (seq_start),
        .seq_abort (seq_abort),
        .n_pulses  (n_pulses),
        .gap       (gap),
        .timeout   (timeout),
        .launch_DL (launch_DL),
        .PL_launch (PL_launch),
        .busy      (busy),
        .seq_done  (seq_done),
        .fault     (fault),
        .pulse_idx (pulse_idx)
    );

    always #5 clk_Seq = ~clk_Seq;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [N_W+3:0] obs();
        return {PL_launch, busy, seq_done, fault, pulse_idx};
    endfunction

    task automatic check(input string name, input logic [N_W+3:0] got, input logic [N_W+3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got pl/busy/done/fault=%b idx=%0d, expected %b idx=%0d",
                     name, got[N_W+3:N_W], got[N_W-1:0], exp[N_W+3:N_W], exp[N_W-1:0]);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle just past the rising edge.
    task automatic step(input logic r, input logic s, input logic a, input logic dl,
                        input int n, input int g, input int to);
        @(negedge clk_Seq);
        rst       = r;
        seq_start = s;
        seq_abort = a;
        launch_DL = dl;
        n_pulses  = N_W'(n);
        gap       = GAP_W'(g);
        timeout   = TO_W'(to);
        @(posedge clk_Seq);
        #1;
    endtask

    function automatic vec_t mk(logic r, logic s, logic a, logic dl, int n, int g, int to,
                                logic pl, logic b, logic d, logic f, int idx);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.dl = dl;
        v.n = n; v.g = g; v.to = to;
        v.pl = pl; v.busy = b; v.done = d; v.fault = f; v.idx = N_W'(idx);
        return v;
    endfunction

    // One sequence: d_tab holds how many cycles PL_launch stays high before launch_DL.
    // abort_at: -1 none, -2 random point, >=0 cycle index counted from the start edge.
    task automatic run_seq(input string name, input int n, input int g, input int to,
                           input int abort_at, input bit noise);
        logic           e_pl [L_MAX];
        logic           e_busy [L_MAX];
        logic           e_done [L_MAX];
        logic           e_fault [L_MAX];
        logic [N_W-1:0] e_idx [L_MAX];
        bit             dl_drv [L_MAX];
        bit             noise_ok [L_MAX];
        int  s = 0;
        int  end_r = 0;
        int  len;
        int  ab;
        int  geff;
        bit  stop = 0;
        logic [N_W-1:0] hold_idx;
        logic           hold_fault;
        logic st, dl;

        geff = (g == 0) ? 1 : g;
        for (int r = 0; r < L_MAX; r++) begin
            e_pl[r] = 0; e_busy[r] = 0; e_done[r] = 0; e_fault[r] = 0; e_idx[r] = '0;
            dl_drv[r] = 0; noise_ok[r] = 0;
        end

        if (n == 0) begin
            e_done[1] = 1;
            end_r = 1;
        end else begin
            for (int k = 0; k < n && !stop; k++) begin
                int q;
                if (to != 0 && d_tab[k] >= to) begin
                    for (int r = s; r < s + to; r++) begin e_pl[r] = 1; e_busy[r] = 1; end
                    for (int r = s + to; r < L_MAX; r++) e_fault[r] = 1;
                    end_r = s + to;
                    stop = 1;
                end else begin
                    q = s + d_tab[k];
                    for (int r = s; r < q; r++) begin e_pl[r] = 1; e_busy[r] = 1; end
                    dl_drv[q] = 1;
                    for (int r = q; r < L_MAX; r++) e_idx[r] = N_W'(k + 1);
                    if (k == n - 1) begin
                        e_done[q + 1] = 1;
                        end_r = q + 1;
                    end else begin
                        for (int r = q; r < q + geff; r++) e_busy[r] = 1;
                        for (int r = q + 1; r <= q + geff; r++) noise_ok[r] = 1;
                        s = q + geff;
                    end
                end
            end
        end
        len = end_r + 3;

        ab = abort_at;
        if (abort_at == -2) ab = int'($urandom_range(0, end_r));
        if (ab >= 0) begin
            hold_idx   = (ab == 0) ? idx_prev : e_idx[ab - 1];
            hold_fault = (ab == 0) ? fault_prev : e_fault[ab - 1];
            for (int r = ab; r < len; r++) begin
                e_pl[r] = 0; e_busy[r] = 0; e_done[r] = 0;
                e_idx[r] = hold_idx; e_fault[r] = hold_fault;
            end
        end

        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, n, g, to);
            check({name, "_lead"}, obs(), {1'b0, 1'b0, 1'b0, fault_prev, idx_prev});
        end

        for (int r = 0; r < len; r++) begin
            if (r == 0)                      st = 1;
            else if (ab >= 0)                st = 1;
            else if (noise && r <= end_r)    st = logic'($urandom_range(0, 1));
            else                             st = 0;
            dl = dl_drv[r] | (noise && noise_ok[r] && ($urandom_range(0, 1) == 1));
            if (r == 0) step(0, st, (r == ab), dl, n, g, to);
            else        step(0, st, (r == ab), dl, int'($urandom_range(0, 7)),
                             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            check($sformatf("%s_r%0d", name, r), obs(),
                  {e_pl[r], e_busy[r], e_done[r], e_fault[r], e_idx[r]});
        end
        idx_prev   = e_idx[len - 1];
        fault_prev = e_fault[len - 1];
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 0, 0, 2, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 2, 0, 0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 2, 0, 0,  0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 2, 0, 0,  0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 2, 0, 0,  0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 2, 0, 0,  1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 2, 0, 0,  1, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 2, 0, 0,  0, 1, 0, 0, 1);
        tbl[8]  = mk(0, 1, 0, 0, 2, 0, 0,  1, 1, 0, 0, 1);
        tbl[9]  = mk(0, 1, 0, 1, 2, 0, 0,  0, 0, 0, 0, 2);
        tbl[10] = mk(0, 0, 0, 0, 2, 0, 0,  0, 0, 1, 0, 2);
        tbl[11] = mk(0, 0, 0, 0, 2, 0, 0,  0, 0, 0, 0, 2);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 3, 2, 0,  1, 1, 0, 0, 0);
        tbl[16] = mk(1, 1, 0, 0, 3, 2, 0,  0, 0, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, 0, 3, 2, 0,  0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 3, 2, 0,  0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 1, 0, 2, 0, 0,  0, 0, 0, 0, 0);
        tbl[20] = mk(0, 1, 0, 0, 2, 0, 0,  0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 2, 0, 0,  0, 0, 0, 0, 0);

        rst = 1; seq_start = 1; seq_abort = 0; launch_DL = 0;
        n_pulses = '0; gap = '0; timeout = '0;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rst, tbl[i].start, tbl[i].abort, tbl[i].dl, tbl[i].n, tbl[i].g, tbl[i].to);
            check($sformatf("tbl%0d", i), obs(),
                  {tbl[i].pl, tbl[i].busy, tbl[i].done, tbl[i].fault, tbl[i].idx});
        end
        idx_prev   = '0;
        fault_prev = 1'b0;

        for (int k = 0; k < 8; k++) d_tab[k] = 4;
        run_seq("n3_gap5", 3, 5, 0, -1, 0);

        for (int k = 0; k < 8; k++) d_tab[k] = 20;
        run_seq("watchdog", 2, 3, 10, -1, 0);
        for (int k = 0; k < 8; k++) d_tab[k] = 2;
        run_seq("fault_clear", 1, 0, 0, -1, 0);

        for (int k = 0; k < 8; k++) d_tab[k] = 3;
        run_seq("abort_gap", 5, 4, 0, 5, 0);
        run_seq("abort_with_dl", 5, 4, 0, 10, 0);
        run_seq("gap0_noise", 3, 0, 0, -1, 1);
        run_seq("n0", 0, 2, 0, -1, 0);

        for (int t = 0; t < 40; t++) begin
            int n, g, to, am;
            n  = int'($urandom_range(0, 4));
            g  = int'($urandom_range(0, 4));
            to = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 9));
            for (int k = 0; k < 8; k++) d_tab[k] = int'($urandom_range(1, 8));
            am = ($urandom_range(0, 3) == 0) ? -2 : -1;
            run_seq($sformatf("rnd%0d", t), n, g, to, am, (am == -1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
